hangman_scoreboard: RTL and testbench

- Downstream stage of the letter-compare controller.
- Consumes one evaluated guess per go cycle: the letter code plus the per-position hit enables.
- Tracks revealed word positions, the letters already guessed, the wrong-guess count and the game outcome (PLAYING/WON/LOST).
- Drives the unmask vector for the HEX letter display and a thermometer "gallows" bar for LEDR.

---
 rtl/hangman_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_hangman_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hangman_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hangman_scoreboard
// Description : Game-state scoreboard for the hangman word game. Takes one
//               evaluated guess per cycle (letter code + per-position hit
//               enables), tracks revealed positions, letters already used,
//               the wrong-guess count and the PLAYING/WON/LOST outcome, and
//               drives the HEX unmask vector and a thermometer gallows bar.
// Revision    : 1.0 - initial release
// ============================================================================
module hangman_scoreboard #(
    parameter int MAX_WRONG = 6,   // wrong guesses that end the game, 1..10
    parameter int LETTER_W  = 5    // letter code width, A=0 .. Z=25
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                new_game,
    input  logic [2:0]          word_len,
    input  logic                guess_valid,
    input  logic [LETTER_W-1:0] guess_letter,
    input  logic [4:0]          hit_mask,
    output logic [4:0]          revealed,
    output logic [3:0]          wrong_count,
    output logic [9:0]          gallows_leds,
    output logic                playing,
    output logic                game_won,
    output logic                game_lost,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                repeat_pulse
);

    localparam int                  NUM_LETTERS = 26;
    localparam logic [LETTER_W-1:0] LAST_LETTER = LETTER_W'(25);
    localparam logic [3:0]          WRONG_LIMIT = 4'(MAX_WRONG);

    typedef enum logic [1:0] {
        ST_PLAYING = 2'd0,
        ST_WON     = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Round registers
    logic [4:0]             active_mask;
    logic [NUM_LETTERS-1:0] guessed_set;

    // Next values for every registered output and round register
    logic [4:0]             active_mask_next;
    logic [NUM_LETTERS-1:0] guessed_set_next;
    logic [4:0]             revealed_next;
    logic [3:0]             wrong_count_next;
    logic [9:0]             gallows_next;
    logic                   hit_next;
    logic                   miss_next;
    logic                   repeat_next;

    // Guess evaluation helpers
    logic [4:0]             len_mask;
    logic [NUM_LETTERS-1:0] letter_onehot;
    logic                   letter_invalid;
    logic                   letter_used;
    logic [4:0]             eff_mask;
    logic [4:0]             revealed_merged;
    logic [3:0]             wrong_inc;
    logic                   clear_round;

    // Decode word_len into the active-position mask; out-of-range lengths mean 5
    always_comb begin
        len_mask = 5'b11111;
        case (word_len)
            3'd1:    len_mask = 5'b00001;
            3'd2:    len_mask = 5'b00011;
            3'd3:    len_mask = 5'b00111;
            3'd4:    len_mask = 5'b01111;
            default: len_mask = 5'b11111;
        endcase
    end

    // Classify the incoming guess: illegal code, repeated letter, effective hits
    always_comb begin
        letter_onehot   = NUM_LETTERS'(1) << guess_letter;
        letter_invalid  = (guess_letter > LAST_LETTER);
        letter_used     = ((guessed_set & letter_onehot) != '0);
        eff_mask        = hit_mask & active_mask;
        revealed_merged = revealed | eff_mask;
        // Count never passes the limit, but saturate anyway so the
        // register cannot run away if the limit is ever reached in PLAYING.
        if (wrong_count >= WRONG_LIMIT) begin
            wrong_inc = WRONG_LIMIT;
        end else begin
            wrong_inc = wrong_count + 4'd1;
        end
        clear_round = !resetn || new_game;
    end

    // Next-state and next-output logic; reset/new_game win over any guess
    always_comb begin
        state_next       = state;
        active_mask_next = active_mask;
        guessed_set_next = guessed_set;
        revealed_next    = revealed;
        wrong_count_next = wrong_count;
        hit_next         = 1'b0;
        miss_next        = 1'b0;
        repeat_next      = 1'b0;

        if (clear_round) begin
            state_next       = ST_PLAYING;
            active_mask_next = len_mask;
            guessed_set_next = '0;
            revealed_next    = '0;
            wrong_count_next = '0;
        end else if ((state == ST_PLAYING) && guess_valid) begin
            if (letter_invalid || letter_used) begin
                // Ignored guess: no penalty and no state change
                repeat_next = 1'b1;
            end else begin
                guessed_set_next = guessed_set | letter_onehot;
                if (eff_mask != '0) begin
                    revealed_next = revealed_merged;
                    hit_next      = 1'b1;
                    if (revealed_merged == active_mask) begin
                        state_next = ST_WON;
                    end
                end else begin
                    wrong_count_next = wrong_inc;
                    miss_next        = 1'b1;
                    if (wrong_inc == WRONG_LIMIT) begin
                        state_next = ST_LOST;
                    end
                end
            end
        end
    end

    // Thermometer decode of the next wrong count; saturates at 10 lit LEDs
    always_comb begin
        gallows_next = '0;
        for (int i = 0; i < 10; i++) begin
            gallows_next[i] = (wrong_count_next > 4'(i));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        state <= state_next;
    end

    // Round registers and registered outputs
    always_ff @(posedge clk) begin
        active_mask  <= active_mask_next;
        guessed_set  <= guessed_set_next;
        revealed     <= revealed_next;
        wrong_count  <= wrong_count_next;
        gallows_leds <= gallows_next;
        hit_pulse    <= hit_next;
        miss_pulse   <= miss_next;
        repeat_pulse <= repeat_next;
    end

    assign playing   = (state == ST_PLAYING);
    assign game_won  = (state == ST_WON);
    assign game_lost = (state == ST_LOST);

endmodule
`default_nettype wire

// File: tb/tb_hangman_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hangman_scoreboard
// Description : Self-checking bench for hangman_scoreboard. A table of
//               per-cycle input/expected-output records is applied in a
//               loop, followed by hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hangman_scoreboard;

    localparam logic [1:0] PL = 2'd0;   // expected PLAYING
    localparam logic [1:0] WN = 2'd1;   // expected WON
    localparam logic [1:0] LS = 2'd2;   // expected LOST

    localparam logic [2:0] NP = 3'b000; // no pulse
    localparam logic [2:0] HP = 3'b100; // hit_pulse
    localparam logic [2:0] MP = 3'b010; // miss_pulse
    localparam logic [2:0] RP = 3'b001; // repeat_pulse

    logic       clk;
    logic       resetn;
    logic       new_game;
    logic [2:0] word_len;
    logic       guess_valid;
    logic [4:0] guess_letter;
    logic [4:0] hit_mask;
    logic [4:0] revealed;
    logic [3:0] wrong_count;
    logic [9:0] gallows_leds;
    logic       playing;
    logic       game_won;
    logic       game_lost;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       repeat_pulse;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       rstn;
        logic       ng;
        logic [2:0] wl;
        logic       gv;
        logic [4:0] letter;
        logic [4:0] mask;
        logic [4:0] exp_rev;
        logic [3:0] exp_wc;
        logic [1:0] exp_st;
        logic [2:0] exp_pul;
    } vec_t;

    vec_t vecs[40];
    int   nvec;

    hangman_scoreboard #(
        .MAX_WRONG (6),
        .LETTER_W  (5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .new_game     (new_game),
        .word_len     (word_len),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
        .hit_mask     (hit_mask),
        .revealed     (revealed),
        .wrong_count  (wrong_count),
        .gallows_leds (gallows_leds),
        .playing      (playing),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .repeat_pulse (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rstn, input logic ng, input logic [2:0] wl,
                                input logic gv, input logic [4:0] letter, input logic [4:0] mask,
                                input logic [4:0] rev, input logic [3:0] wc,
                                input logic [1:0] st, input logic [2:0] pul);
        vec_t v;
        v.rstn = rstn; v.ng = ng; v.wl = wl; v.gv = gv; v.letter = letter; v.mask = mask;
        v.exp_rev = rev; v.exp_wc = wc; v.exp_st = st; v.exp_pul = pul;
        return v;
    endfunction

    function automatic logic [9:0] therm(input logic [3:0] w);
        logic [9:0] t;
        t = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < int'(w)) t[i] = 1'b1;
        end
        return t;
    endfunction

    // Drive one cycle of inputs, then compare all outputs after the edge
    task automatic apply(input vec_t v, input string name);
        logic [24:0] got;
        logic [24:0] exp;
        @(negedge clk);
        resetn       = v.rstn;
        new_game     = v.ng;
        word_len     = v.wl;
        guess_valid  = v.gv;
        guess_letter = v.letter;
        hit_mask     = v.mask;
        @(posedge clk);
        #1;
        got = {revealed, wrong_count, gallows_leds, playing, game_won, game_lost,
               hit_pulse, miss_pulse, repeat_pulse};
        exp = {v.exp_rev, v.exp_wc, therm(v.exp_wc),
               (v.exp_st == PL), (v.exp_st == WN), (v.exp_st == LS), v.exp_pul};
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got rev=%b wc=%0d leds=%b p/w/l=%b%b%b h/m/r=%b%b%b, need rev=%b wc=%0d leds=%b p/w/l=%b%b%b h/m/r=%b",
                     name, revealed, wrong_count, gallows_leds, playing, game_won, game_lost,
                     hit_pulse, miss_pulse, repeat_pulse, v.exp_rev, v.exp_wc, therm(v.exp_wc),
                     (v.exp_st == PL), (v.exp_st == WN), (v.exp_st == LS), v.exp_pul);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        new_game     = 1'b0;
        word_len     = 3'd4;
        guess_valid  = 1'b0;
        guess_letter = '0;
        hit_mask     = '0;

        nvec = 0;
        //                   rstn ng   wl    gv  letter  mask      rev       wc  st  pulse
        vecs[nvec++] = mk(0, 0, 3'd4, 0, 5'd0,  5'b00000, 5'b00000, 0, PL, NP); // reset STAY
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd18, 5'b00001, 5'b00001, 0, PL, HP); // S
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd24, 5'b01000, 5'b01001, 0, PL, HP); // Y
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd18, 5'b00001, 5'b01001, 0, PL, RP); // S again
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd27, 5'b00000, 5'b01001, 0, PL, RP); // code 27
        vecs[nvec++] = mk(1, 0, 3'd4, 0, 5'd0,  5'b00000, 5'b01001, 0, PL, NP); // idle
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd19, 5'b00010, 5'b01011, 0, PL, HP); // T
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd0,  5'b00100, 5'b01111, 0, WN, HP); // A -> won
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd4,  5'b00000, 5'b01111, 0, WN, NP); // ignored
        vecs[nvec++] = mk(1, 1, 3'd4, 0, 5'd0,  5'b00000, 5'b00000, 0, PL, NP); // new game
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd1,  5'b00000, 5'b00000, 1, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd2,  5'b00000, 5'b00000, 2, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd3,  5'b00000, 5'b00000, 3, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd4,  5'b00000, 5'b00000, 4, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd5,  5'b00000, 5'b00000, 5, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd6,  5'b00000, 5'b00000, 6, LS, MP); // lost
        vecs[nvec++] = mk(1, 0, 3'd4, 1, 5'd7,  5'b00000, 5'b00000, 6, LS, NP); // ignored
        vecs[nvec++] = mk(1, 1, 3'd4, 1, 5'd18, 5'b00001, 5'b00000, 0, PL, NP); // ng+guess
        vecs[nvec++] = mk(1, 1, 3'd3, 0, 5'd0,  5'b00000, 5'b00000, 0, PL, NP); // len 3
        vecs[nvec++] = mk(1, 0, 3'd3, 1, 5'd5,  5'b11000, 5'b00000, 1, PL, MP); // eff=0
        vecs[nvec++] = mk(1, 0, 3'd3, 1, 5'd20, 5'b00100, 5'b00100, 1, PL, HP);
        vecs[nvec++] = mk(1, 0, 3'd3, 1, 5'd21, 5'b00011, 5'b00111, 1, WN, HP); // len3 won
        vecs[nvec++] = mk(1, 1, 3'd0, 0, 5'd0,  5'b00000, 5'b00000, 0, PL, NP); // len 0 -> 5
        vecs[nvec++] = mk(1, 0, 3'd0, 1, 5'd3,  5'b00000, 5'b00000, 1, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd0, 1, 5'd4,  5'b00000, 5'b00000, 2, PL, MP);
        vecs[nvec++] = mk(1, 0, 3'd0, 1, 5'd5,  5'b00000, 5'b00000, 3, PL, MP);
        vecs[nvec++] = mk(0, 0, 3'd0, 1, 5'd9,  5'b10000, 5'b00000, 0, PL, NP); // mid reset
        vecs[nvec++] = mk(1, 0, 3'd0, 1, 5'd3,  5'b00000, 5'b00000, 1, PL, MP); // 3 again ok
        vecs[nvec++] = mk(1, 0, 3'd0, 1, 5'd9,  5'b10000, 5'b10000, 1, PL, HP); // bit 4 live
        vecs[nvec++] = mk(1, 0, 3'd1, 1, 5'd10, 5'b00001, 5'b10001, 1, PL, HP); // wl change
        vecs[nvec++] = mk(1, 0, 3'd1, 1, 5'd10, 5'b00001, 5'b10001, 1, PL, RP); // repeat

        for (int i = 0; i < nvec; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Stretched guess_valid: first cycle counts, following cycles are repeats
        apply(mk(1, 1, 3'd5, 0, 5'd0,  5'b00000, 5'b00000, 0, PL, NP), "held_ng");
        apply(mk(1, 0, 3'd5, 1, 5'd7,  5'b00000, 5'b00000, 1, PL, MP), "held_c1");
        apply(mk(1, 0, 3'd5, 1, 5'd7,  5'b00000, 5'b00000, 1, PL, RP), "held_c2");
        apply(mk(1, 0, 3'd5, 1, 5'd7,  5'b00000, 5'b00000, 1, PL, RP), "held_c3");
        apply(mk(1, 0, 3'd5, 0, 5'd7,  5'b00000, 5'b00000, 1, PL, NP), "held_drop");

        // Five-letter word revealed one position at a time
        for (int p = 0; p < 5; p++) begin
            logic [4:0] m;
            logic [4:0] r;
            m = 5'b00001 << p;
            r = 5'((6'b000010 << p) - 6'd1);
            apply(mk(1, 0, 3'd5, 1, 5'(10 + p), m, r, 1, (p == 4) ? WN : PL, HP),
                  $sformatf("win5_p%0d", p));
        end
        apply(mk(1, 0, 3'd5, 0, 5'd0, 5'b00000, 5'b11111, 1, WN, NP), "win5_hold");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
